// File: rtl/maze_port_arbiter.sv
// Two-requester arbiter sharing one maze memory port; round-robin on ties, requests sampled only in IDLE.
// Latency: ack is high in the third cycle after the accepting IDLE edge; one access per 4 cycles.
// Backpressure: requesters hold req/we/row/col until their ack; requests seen outside IDLE are ignored.
module maze_port_arbiter #(
    parameter int maze_width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [maze_width-1:0] row0,
    input  logic [maze_width-1:0] col0,
    input  logic [maze_width-1:0] row1,
    input  logic [maze_width-1:0] col1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rdata0,
    output logic                  rdata1,
    output logic [maze_width-1:0] row,
    output logic [maze_width-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    input  logic                  maze_in,
    output logic                  busy,
    output logic                  gnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t state;
    logic   last_gnt;
    logic   we_lat;
    logic   win;
    logic   win_we;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        win    = (req0 && req1) ? ~last_gnt : req1;
        win_we = win ? we1 : we0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            we_lat   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= 1'b0;
            rdata1   <= 1'b0;
            row      <= '0;
            col      <= '0;
            maze_oe  <= 1'b0;
            maze_we  <= 1'b0;
            busy     <= 1'b0;
            gnt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state    <= ISSUE;
                        gnt      <= win;
                        last_gnt <= win;
                        we_lat   <= win_we;
                        row      <= win ? row1 : row0;
                        col      <= win ? col1 : col0;
                        maze_oe  <= ~win_we;
                        maze_we  <= win_we;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    maze_oe <= 1'b0;
                    maze_we <= 1'b0;
                end
                WAIT: begin
                    state <= ACK;
                    // Read data returns one cycle after the strobe, i.e. during WAIT.
                    if (!we_lat) begin
                        if (gnt) rdata1 <= maze_in;
                        else     rdata0 <= maze_in;
                    end
                    ack0 <= ~gnt;
                    ack1 <= gnt;
                end
                ACK: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed table of single accesses plus sequences for tie, withdrawal, mid-access reset and random protocol.
module tb_maze_port_arbiter;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1, we0, we1;
    logic [W-1:0] row0, col0, row1, col1;
    logic         ack0, ack1, rdata0, rdata1;
    logic [W-1:0] row, col;
    logic         maze_oe, maze_we, maze_in, busy, gnt;

    int n_cmp = 0;
    int n_mis = 0;

    maze_port_arbiter #(.maze_width(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .row0(row0), .col0(col0), .row1(row1), .col1(col1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
        .maze_in(maze_in), .busy(busy), .gnt(gnt)
    );

    always #5 clk = ~clk;

    // Maze memory: a few preset walls, plus every cell written so far.
    bit [4095:0] written;

    function automatic logic preset(input logic [11:0] a);
        return (a == {6'd5, 6'd7}) || (a == {6'd4, 6'd4}) || (a == {6'd0, 6'd63});
    endfunction

    always @(posedge clk) begin
        if (maze_oe) maze_in <= written[{row, col}] | preset({row, col});
        if (maze_we) written[{row, col}] <= 1'b1;
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic         r0, w0;
        logic [W-1:0] rw0, cl0;
        logic         r1, w1;
        logic [W-1:0] rw1, cl1;
        logic         eg, eoe, ewe;
        logic [W-1:0] erow, ecol;
        logic         ed0, ed1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, ackc0, ackc1, viol_rw, viol_ack, nack, nack0, nack1;
        logic mlast, w;
        bit drain;

        //            r0   w0   row0   col0   r1   w1   row1    col1   gnt  oe   we   row     col    rd0  rd1
        vecs[0] = '{1'b1, 1'b0, 6'd5, 6'd7,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd5,  6'd7,  1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 6'd0, 6'd0,  1'b1, 1'b1, 6'd63, 6'd0,  1'b1, 1'b0, 1'b1, 6'd63, 6'd0,  1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 6'd0, 6'd0,  1'b1, 1'b0, 6'd63, 6'd0,  1'b1, 1'b1, 1'b0, 6'd63, 6'd0,  1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 6'd2, 6'd3,  1'b1, 1'b0, 6'd4,  6'd4,  1'b0, 1'b1, 1'b0, 6'd2,  6'd3,  1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 6'd2, 6'd3,  1'b1, 1'b0, 6'd9,  6'd10, 1'b1, 1'b1, 1'b0, 6'd9,  6'd10, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 6'd1, 6'd1,  1'b1, 1'b0, 6'd9,  6'd10, 1'b0, 1'b0, 1'b1, 6'd1,  6'd1,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 6'd1, 6'd1,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd1,  6'd1,  1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 6'd5, 6'd7,  1'b1, 1'b0, 6'd0,  6'd63, 1'b1, 1'b1, 1'b0, 6'd0,  6'd63, 1'b1, 1'b1};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        row0 = '0; col0 = '0; row1 = '0; col1 = '0;
        repeat (2) @(negedge clk);

        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ack", ack0 | ack1, 1'b0);
        chk1("rst_strobe", maze_oe | maze_we, 1'b0);
        chk1("rst_rdata", rdata0 | rdata1, 1'b0);
        chk1("rst_gnt", gnt, 1'b0);
        chkw("rst_row", row, '0);
        chkw("rst_col", col, '0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            req0 = vecs[i].r0; we0 = vecs[i].w0; row0 = vecs[i].rw0; col0 = vecs[i].cl0;
            req1 = vecs[i].r1; we1 = vecs[i].w1; row1 = vecs[i].rw1; col1 = vecs[i].cl1;
            cyc();
            chk1($sformatf("v%0d_issue_busy", i), busy, 1'b1);
            chk1($sformatf("v%0d_gnt", i), gnt, vecs[i].eg);
            chkw($sformatf("v%0d_row", i), row, vecs[i].erow);
            chkw($sformatf("v%0d_col", i), col, vecs[i].ecol);
            chk1($sformatf("v%0d_oe", i), maze_oe, vecs[i].eoe);
            chk1($sformatf("v%0d_we", i), maze_we, vecs[i].ewe);
            cyc();
            chk1($sformatf("v%0d_wait_strobe", i), maze_oe | maze_we, 1'b0);
            chkw($sformatf("v%0d_wait_row", i), row, vecs[i].erow);
            cyc();
            chk1($sformatf("v%0d_ack0", i), ack0, ~vecs[i].eg);
            chk1($sformatf("v%0d_ack1", i), ack1, vecs[i].eg);
            chk1($sformatf("v%0d_rdata0", i), rdata0, vecs[i].ed0);
            chk1($sformatf("v%0d_rdata1", i), rdata1, vecs[i].ed1);
            req0 = 1'b0; req1 = 1'b0;
            cyc();
            chk1($sformatf("v%0d_idle_busy", i), busy, 1'b0);
            chk1($sformatf("v%0d_idle_ack", i), ack0 | ack1, 1'b0);
        end

        // Withdrawn request: req0 high only across the accepting edge; cell (2,3) is clear.
        req0 = 1'b1; we0 = 1'b0; row0 = 6'd2; col0 = 6'd3;
        cyc();
        req0 = 1'b0;
        chk1("wd_issue_oe", maze_oe, 1'b1);
        nack0 = 0; nack1 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (ack0) nack0++;
            if (ack1) nack1++;
        end
        chki("wd_ack0_count", nack0, 1);
        chki("wd_ack1_count", nack1, 0);
        chk1("wd_rdata0", rdata0, 1'b0);
        chk1("wd_idle", busy, 1'b0);

        // Reset during WAIT: requester 0 owns the access so the pointer would favour 1 without reset.
        req0 = 1'b1; we0 = 1'b0; row0 = 6'd5; col0 = 6'd7;
        cyc();
        cyc();
        chk1("mr_wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_ack", ack0 | ack1, 1'b0);
        chk1("mr_rdata1", rdata1, 1'b0);
        chk1("mr_strobe", maze_oe | maze_we, 1'b0);
        chkw("mr_row", row, '0);
        chkw("mr_col", col, '0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nack = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (ack0 || ack1) nack++;
            chk1($sformatf("mr_quiet_busy%0d", k), busy, 1'b0);
        end
        chki("mr_no_ack", nack, 0);
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        row0 = 6'd2; col0 = 6'd3; row1 = 6'd4; col1 = 6'd4;
        cyc();
        chk1("mr_tie_gnt", gnt, 1'b0);
        cyc();
        cyc();
        chk1("mr_tie_ack0", ack0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        cyc();

        // Continuous tie from the first edge after reset: owners 0,1,0,1, ack in every 4th cycle.
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        nack = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (ack0 || ack1) nack++;
            chk1($sformatf("tie_busy%0d", k), busy, (k % 4) != 0);
            chk1($sformatf("tie_ack0_%0d", k), ack0, ((k % 4) == 3) && ((((k - 3) / 4) % 2) == 0));
            chk1($sformatf("tie_ack1_%0d", k), ack1, ((k % 4) == 3) && ((((k - 3) / 4) % 2) == 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        chki("tie_ack_total", nack, 4);

        // Random protocol run; the DUT pointer ends at 1 after the 0,1,0,1 sequence.
        acc0 = 0; acc1 = 0; ackc0 = 0; ackc1 = 0; viol_rw = 0; viol_ack = 0;
        mlast = 1'b1;
        drain = 1'b0;
        for (int i = 0; i < 1030; i++) begin
            if (i == 1000) drain = 1'b1;
            if (maze_oe && maze_we) viol_rw++;
            if (ack0 && ack1) viol_ack++;
            if (ack0) ackc0++;
            if (ack1) ackc1++;
            if (ack0 || (!req0 && $urandom_range(2, 0) == 0)) begin
                req0 = !drain && (ack0 ? 1'($urandom_range(1, 0)) : 1'b1);
                we0 = 1'($urandom_range(1, 0));
                row0 = 6'($urandom_range(63, 0));
                col0 = 6'($urandom_range(63, 0));
            end
            if (ack1 || (!req1 && $urandom_range(2, 0) == 0)) begin
                req1 = !drain && (ack1 ? 1'($urandom_range(1, 0)) : 1'b1);
                we1 = 1'($urandom_range(1, 0));
                row1 = 6'($urandom_range(63, 0));
                col1 = 6'($urandom_range(63, 0));
            end
            if (!busy && (req0 || req1)) begin
                w = (req0 && req1) ? ~mlast : req1;
                mlast = w;
                if (w) acc1++;
                else   acc0++;
            end
            cyc();
        end
        chki("rand_ack0_vs_accepted", ackc0, acc0);
        chki("rand_ack1_vs_accepted", ackc1, acc1);
        chki("rand_oe_and_we", viol_rw, 0);
        chki("rand_ack_overlap", viol_ack, 0);
        chk1("rand_final_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
